// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types and constants for the clock_core timekeeping block
package clock_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_HH = 2'd1,
        SET_MM = 2'd2,
        SET_SS = 2'd3
    } mode_e;

    localparam logic [1:0] BLINK_HH   = 2'b00;
    localparam logic [1:0] BLINK_MM   = 2'b01;
    localparam logic [1:0] BLINK_SS   = 2'b10;
    localparam logic [1:0] BLINK_NONE = 2'b11;

    localparam logic [7:0] HH_MAX = 8'h23;
    localparam logic [7:0] MS_MAX = 8'h59;

    function automatic logic [1:0] blink_of(input mode_e m);
        case (m)
            SET_HH:  blink_of = BLINK_HH;
            SET_MM:  blink_of = BLINK_MM;
            SET_SS:  blink_of = BLINK_SS;
            default: blink_of = BLINK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bcd_counter2.sv
// rtl/bcd_counter2.sv - two-digit BCD up/down register with wrap at a programmable maximum
module bcd_counter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] max_val,
    input  logic       inc,
    input  logic       dec,
    input  logic       clear,
    output logic [7:0] value,
    output logic       carry_out
);

    logic [7:0] value_next;

    // Priority clear > inc > dec; the owner keeps inc and dec exclusive.
    always_comb begin
        value_next = value;
        if (clear) begin
            value_next = 8'h00;
        end else if (inc) begin
            if (value == max_val)
                value_next = 8'h00;
            else if (value[3:0] == 4'd9)
                value_next = {value[7:4] + 4'd1, 4'd0};
            else
                value_next = {value[7:4], value[3:0] + 4'd1};
        end else if (dec) begin
            if (value == 8'h00)
                value_next = max_val;
            else if (value[3:0] == 4'd0)
                value_next = {value[7:4] - 4'd1, 4'd9};
            else
                value_next = {value[7:4], value[3:0] - 4'd1};
        end
    end

    assign carry_out = inc && !clear && (value == max_val);

    always_ff @(posedge clk) begin
        if (!rst_n)
            value <= 8'h00;
        else
            value <= value_next;
    end

endmodule

// File: rtl/clock_core.sv
// rtl/clock_core.sv - HH:MM:SS timekeeping and set-mode controller; CLOCK_SS_ZERO_EN makes SET_SS inc/dec zero the seconds
module clock_core
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       blink_en,
    output logic [1:0] blink_sel
);

    localparam int PW = $clog2(CLK_HZ);
    localparam int BW = $clog2(CLK_HZ / 4);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(CLK_HZ / 4 - 1);

    mode_e         mode, mode_next;
    logic [1:0]    blink_sel_next;
    logic [PW-1:0] presc;
    logic [BW-1:0] blink_cnt;
    logic          running, tick, inc_ok, dec_ok;
    logic          ss_inc, ss_dec, ss_clr, ss_carry;
    logic          mm_inc, mm_dec, mm_carry;
    logic          hh_inc, hh_dec;

    assign running = (mode == RUN);
    assign tick    = running && (presc == PRESC_MAX);
    // Mode press and simultaneous inc+dec both suppress field edits.
    assign inc_ok  = !running && btn_inc && !btn_dec && !btn_mode;
    assign dec_ok  = !running && btn_dec && !btn_inc && !btn_mode;

    always_comb begin
        mode_next = mode;
        if (btn_mode) begin
            case (mode)
                RUN:     mode_next = SET_HH;
                SET_HH:  mode_next = SET_MM;
                SET_MM:  mode_next = SET_SS;
                default: mode_next = RUN;
            endcase
        end
        blink_sel_next = blink_of(mode_next);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode      <= RUN;
            blink_sel <= BLINK_NONE;
        end else begin
            mode      <= mode_next;
            blink_sel <= blink_sel_next;
        end
    end

`ifdef CLOCK_SS_ZERO_EN
    assign ss_clr = (mode == SET_SS) && (inc_ok || dec_ok);
    assign ss_inc = tick;
    assign ss_dec = 1'b0;
`else
    assign ss_clr = 1'b0;
    assign ss_inc = tick || ((mode == SET_SS) && inc_ok);
    assign ss_dec = (mode == SET_SS) && dec_ok;
`endif

    // Carries only ripple while running; edits never touch neighbouring fields.
    assign mm_inc = (running && ss_carry) || ((mode == SET_MM) && inc_ok);
    assign mm_dec = (mode == SET_MM) && dec_ok;
    assign hh_inc = (running && mm_carry) || ((mode == SET_HH) && inc_ok);
    assign hh_dec = (mode == SET_HH) && dec_ok;

    always_ff @(posedge clk) begin
        if (!rst_n)
            presc <= '0;
        else if ((mode == SET_SS && mode_next == RUN) || ss_clr)
            presc <= '0;
        else if (running)
            presc <= tick ? '0 : presc + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || btn_mode || mode_next == RUN) begin
            blink_cnt <= '0;
            blink_en  <= 1'b0;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt <= '0;
            blink_en  <= !blink_en;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    bcd_counter2 u_ss (
        .clk(clk), .rst_n(rst_n), .max_val(MS_MAX),
        .inc(ss_inc), .dec(ss_dec), .clear(ss_clr),
        .value(ss), .carry_out(ss_carry)
    );

    bcd_counter2 u_mm (
        .clk(clk), .rst_n(rst_n), .max_val(MS_MAX),
        .inc(mm_inc), .dec(mm_dec), .clear(1'b0),
        .value(mm), .carry_out(mm_carry)
    );

    bcd_counter2 u_hh (
        .clk(clk), .rst_n(rst_n), .max_val(HH_MAX),
        .inc(hh_inc), .dec(hh_dec), .clear(1'b0),
        .value(hh), .carry_out()
    );

endmodule

// File: tb/tb_clock_core.sv
// tb/tb_clock_core.sv - directed self-checking bench for clock_core at CLK_HZ = 8
module tb_clock_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode, btn_inc, btn_dec;
    logic [7:0] hh, mm, ss;
    logic       blink_en;
    logic [1:0] blink_sel;

    int n_checks = 0;
    int n_fail   = 0;
    logic bad_bcd;
    logic exp_blink [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] ss_edit, ss_after;

    clock_core #(.CLK_HZ(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .hh(hh), .mm(mm), .ss(ss),
        .blink_en(blink_en), .blink_sel(blink_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s);
        check({tag, "_hh"}, {24'd0, hh}, {24'd0, h});
        check({tag, "_mm"}, {24'd0, mm}, {24'd0, m});
        check({tag, "_ss"}, {24'd0, ss}, {24'd0, s});
    endtask

    task automatic pulse(input logic m, input logic i, input logic d);
        btn_mode = m;
        btn_inc  = i;
        btn_dec  = d;
        @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
    endtask

    function automatic logic legal(input logic [7:0] v, input logic [7:0] max_v);
        return (v[3:0] <= 4'd9) && (v <= max_v);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
        repeat (3) @(negedge clk);
        check_time("reset", 8'h00, 8'h00, 8'h00);
        check("reset_sel", blink_sel, 2'b11);
        check("reset_en", blink_en, 1'b0);
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        check("pre_first_tick", ss, 8'h00);
        @(negedge clk);
        check("first_tick", ss, 8'h01);

        // SET_HH: blink phase and hour wrap in both directions
        pulse(1, 0, 0);
        check("sel_hh", blink_sel, 2'b00);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("blink_hh", blink_en, exp_blink[i]);
        end
        pulse(0, 0, 1);
        check_time("hh_dec_wrap", 8'h23, 8'h00, 8'h01);
        pulse(0, 1, 0);
        check("hh_inc_wrap", hh, 8'h00);
        pulse(0, 0, 1);
        check("hh_dec_again", hh, 8'h23);

        pulse(1, 0, 0);
        check("sel_mm", blink_sel, 2'b01);
        check("blink_clear_mm", blink_en, 1'b0);
        pulse(0, 0, 1);
        check_time("mm_dec_wrap", 8'h23, 8'h59, 8'h01);

        pulse(1, 0, 0);
        check("sel_ss", blink_sel, 2'b10);
        pulse(0, 0, 1);
        check_time("ss_to_zero", 8'h23, 8'h59, 8'h00);

        // Run to 23:59:59 and through the full rollover
        pulse(1, 0, 0);
        check("sel_run", blink_sel, 2'b11);
        check("blink_run", blink_en, 1'b0);
        bad_bcd = 1'b0;
        for (int i = 1; i <= 480; i++) begin
            @(negedge clk);
            if (!legal(hh, 8'h23) || !legal(mm, 8'h59) || !legal(ss, 8'h59)) bad_bcd = 1'b1;
            if (i == 7)   check("exit_pre_tick", ss, 8'h00);
            if (i == 8)   check("exit_tick", ss, 8'h01);
            if (i == 479) check_time("pre_roll", 8'h23, 8'h59, 8'h59);
            if (i == 480) check_time("rollover", 8'h00, 8'h00, 8'h00);
        end
        check("bcd_legal", bad_bcd, 1'b0);

        // SET_MM: inc+dec together ignored, mode beats inc
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        repeat (30) pulse(0, 1, 0);
        check("mm_set_30", mm, 8'h30);
        pulse(0, 1, 1);
        check("mm_both_btn", mm, 8'h30);
        pulse(1, 1, 0);
        check("mode_wins_sel", blink_sel, 2'b10);
        check_time("mode_wins", 8'h00, 8'h30, 8'h00);

        pulse(1, 0, 0);
        for (int i = 1; i <= 328; i++) begin
            @(negedge clk);
            if (i == 7)   check("run2_pre_tick", ss, 8'h00);
            if (i == 8)   check("run2_tick", ss, 8'h01);
            if (i == 328) check_time("run2_41", 8'h00, 8'h30, 8'h41);
        end

        // SET_SS edit, freeze, and first tick after exit
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        check("sel_ss2", blink_sel, 2'b10);
`ifdef CLOCK_SS_ZERO_EN
        ss_edit  = 8'h00;
        ss_after = 8'h01;
`else
        ss_edit  = 8'h42;
        ss_after = 8'h43;
`endif
        pulse(0, 1, 0);
        check("ss_edit", ss, ss_edit);
        repeat (50) @(negedge clk);
        check_time("frozen", 8'h00, 8'h30, ss_edit);
        pulse(1, 0, 0);
        repeat (7) @(negedge clk);
        check("run3_pre_tick", ss, ss_edit);
        @(negedge clk);
        check("run3_tick", ss, ss_after);

        // Reset mid-edit with the field blanked
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("mid_edit_sel", blink_sel, 2'b01);
        check("mid_edit_en", blink_en, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check_time("reset_edit", 8'h00, 8'h00, 8'h00);
        check("reset_edit_sel", blink_sel, 2'b11);
        check("reset_edit_en", blink_en, 1'b0);
        rst_n = 1'b1;
        pulse(0, 1, 0);
        check_time("run_inc_ignored", 8'h00, 8'h00, 8'h00);
        pulse(0, 0, 1);
        check_time("run_dec_ignored", 8'h00, 8'h00, 8'h00);
        pulse(1, 0, 0);
        check("after_reset_mode", blink_sel, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
